mcp2515_cmd_sequencer: RTL and testbench
========================================

Name: mcp2515_cmd_sequencer

Overview:
- Sits directly upstream of the SPI byte master.
- Turns single host commands (register read/write, bit-modify, reset, status, request-to-send) into the multi-byte MCP2515 SPI frames.
- Drives the byte master with one start/data_in handshake per byte and owns the device chip-select, since the byte master never raises its own CS.
- Collects the byte master's data_out and returns read data to the host.

Parameters:
- CS_SETUP_CYC, 16: clk_50MHz cycles from cs_n low to the first byte start.
- CS_HOLD_CYC, 64: cycles between the last byte done and cs_n high; also the minimum cs_n-high gap before the next frame.
- TIMEOUT_CYC, 8192: per-byte watchdog limit; used only with SEQ_TIMEOUT_EN.

Ports:
- clk_50MHz  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  0 RESET, 1 READ, 2 WRITE, 3 BIT_MODIFY, 4 READ_STATUS, 5 RTS, 6-7 illegal
- cmd_addr  in  8  register address; for RTS, bits [2:0] are the TXB mask
- cmd_wdata  in  8  write data (WRITE, BIT_MODIFY)
- cmd_mask  in  8  bit-modify mask
- rsp_valid  out  1  one-cycle pulse when a command completes
- rsp_rdata  out  8  read data (READ, READ_STATUS), else 0
- rsp_err  out  1  illegal op or timeout
- spi_start  out  1  to byte master start
- spi_tx  out  8  to byte master data_in
- spi_rx  in  8  from byte master data_out
- spi_sending  in  1  from byte master sending
- spi_done  in  1  from byte master done
- cs_n  out  1  MCP2515 chip select

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, spi_start=0, spi_tx=0, cs_n=1, state IDLE.
- spi_sending and spi_done come from the divided-clock domain; both pass through 2-flop synchronisers before use. spi_rx is sampled only after synchronised done is high, when it is stable.
- Command accept: on cmd_valid&&cmd_ready, latch op/addr/wdata/mask, drop cmd_ready, build the byte list. The list length N is set by op:
  - RESET: C0 (N=1)
  - READ: 03, addr, 00 (N=3)
  - WRITE: 02, addr, wdata (N=3)
  - BIT_MODIFY: 05, addr, mask, wdata (N=4)
  - READ_STATUS: A0, 00 (N=2)
  - RTS: 80|addr[2:0] (N=1)
- Illegal op: go straight to RESP with rsp_err=1; cs_n is not touched.
- State flow: IDLE -> SETUP -> START -> WAIT_BUSY -> WAIT_DONE -> (NEXT -> START | HOLD) -> RESP -> IDLE.
  - SETUP: cs_n=0, count CS_SETUP_CYC.
  - START: spi_tx=byte[i], spi_start=1.
  - WAIT_BUSY: hold spi_start until sync sending=1, then drop it.
  - WAIT_DONE: wait for sync sending=0 && sync done=1, then capture spi_rx into rx_last. Increment i; if i==N go to HOLD, else NEXT, which waits one cycle before START.
  - HOLD: count CS_HOLD_CYC, then cs_n=1.
  - RESP: rsp_valid=1 for one cycle; rsp_rdata=rx_last for READ/READ_STATUS, else 0. Then return to IDLE.
- Back-to-back commands: cmd_ready rises in the cycle after RESP, so the minimum cs_n-high time is at least CS_HOLD_CYC + CS_SETUP_CYC.
- cmd_valid while busy is ignored; the host holds it until cmd_ready.
- Reset mid-frame: immediate cs_n=1 and spi_start=0; the partial frame is discarded and no response is issued.
- Byte counter is 3 bits; N never exceeds 4.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined: a 14-bit watchdog counts cycles in WAIT_BUSY+WAIT_DONE and clears at each START. At TIMEOUT_CYC it forces spi_start=0, HOLD, then RESP with rsp_err=1 and rsp_rdata=0.
- Undefined: no watchdog; the sequencer waits forever and rsp_err flags only illegal ops.

Decomposition:
- Shared package mcp2515_pkg:
  - op encodings OP_RESET..OP_RTS
  - MCP2515 instruction constants (C0, 03, 02, 05, A0, 80)
  - state enum
  - MAX_FRAME_BYTES=4
- One natural sub-module: sync_2ff (1-bit, reset to 0), instantiated for spi_sending and spi_done.

Test Plan:
- WRITE addr=0x0F data=0x80 (byte master plus MCP2515 slave model) -> MOSI bytes 02,0F,80 under a single cs_n low; rsp_valid pulse with rsp_err=0 and rsp_rdata=0.
- READ addr=0x0E, slave returns 0x40 on 3rd byte -> rsp_rdata=0x40; cs_n low for exactly one frame; cmd_ready=0 throughout.
- BIT_MODIFY addr=0x2B mask=0x03 data=0x01, then back-to-back RTS addr=0x01 -> frames 05,2B,03,01 and 81; cs_n-high gap ≥ CS_HOLD_CYC+CS_SETUP_CYC.
- cmd_op=7 -> rsp_valid with rsp_err=1 within 3 cycles; cs_n stays 1 and spi_start is never asserted.
- reset_n low during the 2nd byte of READ -> cs_n=1 and spi_start=0 immediately; no rsp_valid; next READ_STATUS completes normally.
- SEQ_TIMEOUT_EN, spi_sending tied 0 -> after TIMEOUT_CYC, rsp_err=1 and cs_n returns to 1; without the macro, no response.

Source files
------------

// File: rtl/mcp2515_pkg.sv
// Shared definitions for the MCP2515 command sequencer: host op codes,
// MCP2515 SPI instruction bytes, sequencer state encoding and frame helpers.
package mcp2515_pkg;

  localparam int MAX_FRAME_BYTES = 4;

  // Host command op codes; 6 and 7 are illegal.
  localparam logic [2:0] OP_RESET       = 3'd0;
  localparam logic [2:0] OP_READ        = 3'd1;
  localparam logic [2:0] OP_WRITE       = 3'd2;
  localparam logic [2:0] OP_BIT_MODIFY  = 3'd3;
  localparam logic [2:0] OP_READ_STATUS = 3'd4;
  localparam logic [2:0] OP_RTS         = 3'd5;

  // MCP2515 SPI instruction bytes.
  localparam logic [7:0] INS_RESET       = 8'hC0;
  localparam logic [7:0] INS_READ        = 8'h03;
  localparam logic [7:0] INS_WRITE       = 8'h02;
  localparam logic [7:0] INS_BIT_MODIFY  = 8'h05;
  localparam logic [7:0] INS_READ_STATUS = 8'hA0;
  localparam logic [7:0] INS_RTS         = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_NEXT,
    ST_HOLD,
    ST_RESP
  } seq_state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_RTS);
  endfunction

  function automatic logic op_returns_data(input logic [2:0] op);
    return (op == OP_READ) || (op == OP_READ_STATUS);
  endfunction

  // Number of SPI bytes in the frame for a given op (0 for illegal ops).
  function automatic logic [2:0] frame_len(input logic [2:0] op);
    case (op)
      OP_RESET:       return 3'd1;
      OP_READ:        return 3'd3;
      OP_WRITE:       return 3'd3;
      OP_BIT_MODIFY:  return 3'd4;
      OP_READ_STATUS: return 3'd2;
      OP_RTS:         return 3'd1;
      default:        return 3'd0;
    endcase
  endfunction

  // Frame byte list packed with byte 0 (sent first) in the low byte.
  function automatic logic [8*MAX_FRAME_BYTES-1:0] frame_bytes(
      input logic [2:0] op,
      input logic [7:0] addr,
      input logic [7:0] wdata,
      input logic [7:0] mask);
    case (op)
      OP_RESET:       return {24'h0, INS_RESET};
      OP_READ:        return {8'h00, 8'h00, addr, INS_READ};
      OP_WRITE:       return {8'h00, wdata, addr, INS_WRITE};
      OP_BIT_MODIFY:  return {wdata, mask, addr, INS_BIT_MODIFY};
      OP_READ_STATUS: return {16'h0, 8'h00, INS_READ_STATUS};
      OP_RTS:         return {24'h0, INS_RTS | {5'b0, addr[2:0]}};
      default:        return '0;
    endcase
  endfunction

endpackage

// File: rtl/mcp2515_cmd_sequencer_if.sv
// Host-side command/response bundle of the MCP2515 command sequencer.
interface mcp2515_cmd_sequencer_if;
  import mcp2515_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [7:0] cmd_mask;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  // Host side issues commands and receives responses.
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Sequencer side accepts commands and returns responses.
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single control bit from the divided SPI clock
// domain; resets to 0.
module sync_2ff (
  input  logic clk_50MHz,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  // Shift the asynchronous bit through two flops.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/mcp2515_cmd_sequencer.sv
// MCP2515 command sequencer: expands one host command into an MCP2515 SPI
// frame, drives the byte master one byte at a time, owns chip-select and
// returns read data. Optional per-byte watchdog: define SEQ_TIMEOUT_EN.
module mcp2515_cmd_sequencer
  import mcp2515_pkg::*;
#(
  parameter int CS_SETUP_CYC = 16,
  parameter int CS_HOLD_CYC  = 64
`ifdef SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC  = 8192
`endif
) (
  input  logic                         clk_50MHz,
  input  logic                         reset_n,
  mcp2515_cmd_sequencer_if.slave       host,
  output logic                         spi_start_o,
  output logic [7:0]                   spi_tx_o,
  input  logic [7:0]                   spi_rx_i,
  input  logic                         spi_sending_i,
  input  logic                         spi_done_i,
  output logic                         cs_n_o
);

  localparam int CNT_MAX = (CS_HOLD_CYC > CS_SETUP_CYC) ? CS_HOLD_CYC : CS_SETUP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // cs_n must stay high this long between frames so that the device sees a
  // full hold plus setup interval even when commands arrive back to back.
  localparam int MIN_GAP = CS_HOLD_CYC + CS_SETUP_CYC;
  localparam int GAP_W   = $clog2(MIN_GAP + 1);

  seq_state_e                   state_q;
  logic                         cmd_ready_q;
  logic                         rsp_valid_q;
  logic [7:0]                   rsp_rdata_q;
  logic                         rsp_err_q;
  logic                         spi_start_q;
  logic [7:0]                   spi_tx_q;
  logic                         cs_n_q;
  logic [2:0]                   op_q;
  logic [8*MAX_FRAME_BYTES-1:0] frame_q;
  logic [2:0]                   len_q;
  logic [2:0]                   idx_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [7:0]                   rx_last_q;
  logic                         timeout_q;
  logic [GAP_W-1:0]             gap_q;
  logic                         gap_ok;
  logic                         wd_expire;

  // Synchronised byte-master status: bit 0 sending, bit 1 done.
  logic [1:0] spi_async;
  logic [1:0] spi_sync;
  logic       sending_s;
  logic       done_s;

  assign spi_async = {spi_done_i, spi_sending_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      sync_2ff u_sync (
        .clk_50MHz (clk_50MHz),
        .reset_n   (reset_n),
        .d_i       (spi_async[gi]),
        .q_o       (spi_sync[gi])
      );
    end
  endgenerate

  assign sending_s = spi_sync[0];
  assign done_s    = spi_sync[1];

  // Count cs_n-high cycles, saturating at the minimum inter-frame gap.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      gap_q <= GAP_W'(MIN_GAP);
    end else if (!cs_n_q) begin
      gap_q <= '0;
    end else if (gap_q != GAP_W'(MIN_GAP)) begin
      gap_q <= gap_q + 1'b1;
    end
  end

  assign gap_ok = (gap_q == GAP_W'(MIN_GAP));

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = 14;
  logic [WD_W-1:0] wdog_q;
  logic            in_wait;

  assign in_wait   = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);
  assign wd_expire = in_wait && (wdog_q == WD_W'(TIMEOUT_CYC - 1));

  // Per-byte watchdog: restarts at every byte start, counts while waiting.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
    end else if (state_q == ST_START) begin
      wdog_q <= '0;
    end else if (in_wait && !wd_expire) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  // Frame sequencer with registered host, byte-master and chip-select outputs.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      spi_start_q <= 1'b0;
      spi_tx_q    <= 8'h00;
      cs_n_q      <= 1'b1;
      op_q        <= 3'd0;
      frame_q     <= '0;
      len_q       <= 3'd0;
      idx_q       <= 3'd0;
      cnt_q       <= '0;
      rx_last_q   <= 8'h00;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (host.cmd_valid && cmd_ready_q) begin
            op_q        <= host.cmd_op;
            frame_q     <= frame_bytes(host.cmd_op, host.cmd_addr,
                                       host.cmd_wdata, host.cmd_mask);
            len_q       <= frame_len(host.cmd_op);
            idx_q       <= 3'd0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            if (!op_is_legal(host.cmd_op)) begin
              // Illegal ops never touch the bus.
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 8'h00;
              state_q     <= ST_RESP;
            end else begin
              state_q <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (cs_n_q) begin
            if (gap_ok) begin
              cs_n_q <= 1'b0;
            end
          end else if (cnt_q == CNT_W'(CS_SETUP_CYC - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_START;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_START: begin
          spi_tx_q    <= frame_q[{idx_q[1:0], 3'b000} +: 8];
          spi_start_q <= 1'b1;
          state_q     <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (wd_expire) begin
            spi_start_q <= 1'b0;
            timeout_q   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ST_HOLD;
          end else if (sending_s) begin
            spi_start_q <= 1'b0;
            state_q     <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (wd_expire) begin
            timeout_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_HOLD;
          end else if (!sending_s && done_s) begin
            rx_last_q <= spi_rx_i;
            idx_q     <= idx_q + 3'd1;
            if (idx_q + 3'd1 == len_q) begin
              cnt_q   <= '0;
              state_q <= ST_HOLD;
            end else begin
              state_q <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          state_q <= ST_START;
        end
        ST_HOLD: begin
          if (cnt_q == CNT_W'(CS_HOLD_CYC - 1)) begin
            cs_n_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= timeout_q;
            rsp_rdata_q <= (op_returns_data(op_q) && !timeout_q) ? rx_last_q : 8'h00;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign host.cmd_ready = cmd_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_rdata = rsp_rdata_q;
  assign host.rsp_err   = rsp_err_q;
  assign spi_start_o    = spi_start_q;
  assign spi_tx_o       = spi_tx_q;
  assign cs_n_o         = cs_n_q;

endmodule

// File: tb/tb_mcp2515_cmd_sequencer.sv
// Directed bench for mcp2515_cmd_sequencer with a behavioural SPI byte
// master / MCP2515 slave model. Build with SEQ_TIMEOUT_EN to exercise the
// watchdog response.
module tb_mcp2515_cmd_sequencer;

  logic       clk_50MHz = 1'b0;
  logic       reset_n;
  logic       spi_start;
  logic [7:0] spi_tx;
  logic [7:0] spi_rx;
  logic       spi_sending;
  logic       spi_done;
  logic       cs_n;

  mcp2515_cmd_sequencer_if host_if ();

  mcp2515_cmd_sequencer dut (
    .clk_50MHz     (clk_50MHz),
    .reset_n       (reset_n),
    .host          (host_if),
    .spi_start_o   (spi_start),
    .spi_tx_o      (spi_tx),
    .spi_rx_i      (spi_rx),
    .spi_sending_i (spi_sending),
    .spi_done_i    (spi_done),
    .cs_n_o        (cs_n)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // Byte master / slave model state.
  logic [7:0] mosi_q [$];
  logic [7:0] slave_rx [4];
  bit         model_stuck = 1'b0;
  int         frame_id    = 0;
  int         model_fid   = 0;
  int         bidx        = 0;
  int         start_no_cs = 0;

  // Bus monitors (single writer, tests take baselines).
  int cs_high_run   = 0;
  int last_gap      = 0;
  int start_cycles  = 0;
  int cs_low_cycles = 0;
  int rsp_cycles    = 0;

  always @(negedge cs_n) frame_id++;

  always @(negedge clk_50MHz) begin
    if (spi_start === 1'b1) start_cycles++;
    if (rsp_valid_w === 1'b1) rsp_cycles++;
    if (cs_n === 1'b0) begin
      cs_low_cycles++;
      if (cs_high_run != 0) last_gap = cs_high_run;
      cs_high_run = 0;
    end else begin
      cs_high_run++;
    end
  end

  logic rsp_valid_w;
  assign rsp_valid_w = host_if.rsp_valid;

  // Byte master: sees start, raises sending, later drops it with done and
  // presents the slave's reply byte for this position in the frame.
  initial begin
    spi_sending = 1'b0;
    spi_done    = 1'b0;
    spi_rx      = 8'h00;
    forever begin
      @(posedge clk_50MHz); #1;
      if (spi_start === 1'b1 && !model_stuck) begin
        if (cs_n !== 1'b0) start_no_cs++;
        if (frame_id != model_fid) begin
          model_fid = frame_id;
          bidx      = 0;
        end
        mosi_q.push_back(spi_tx);
        repeat (2) @(posedge clk_50MHz);
        #1;
        spi_sending = 1'b1;
        spi_done    = 1'b0;
        repeat (16) @(posedge clk_50MHz);
        #1;
        spi_rx      = slave_rx[bidx % 4];
        bidx++;
        spi_sending = 1'b0;
        spi_done    = 1'b1;
      end
    end
  end

  task automatic issue_cmd(input logic [2:0] op, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic [7:0] mask,
                           output bit ok);
    int n;
    @(negedge clk_50MHz);
    host_if.cmd_op    = op;
    host_if.cmd_addr  = addr;
    host_if.cmd_wdata = wdata;
    host_if.cmd_mask  = mask;
    host_if.cmd_valid = 1'b1;
    n = 0;
    while (host_if.cmd_ready !== 1'b1 && n < 500) begin
      @(negedge clk_50MHz);
      n++;
    end
    ok = (host_if.cmd_ready === 1'b1);
    @(posedge clk_50MHz); #1;
    host_if.cmd_valid = 1'b0;
    $display("cmd op=%0d addr=%02h wdata=%02h mask=%02h accepted=%0d", op, addr, wdata, mask, ok);
  endtask

  task automatic wait_rsp(input int budget, output bit got, output logic [7:0] rdata,
                          output logic err, output int lat, output int busy_bad,
                          output logic post_valid, output logic post_ready);
    got = 1'b0; rdata = 8'h00; err = 1'b0; lat = 0; busy_bad = 0;
    post_valid = 1'b0; post_ready = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_50MHz);
      if (host_if.rsp_valid === 1'b1) begin
        got   = 1'b1;
        rdata = host_if.rsp_rdata;
        err   = host_if.rsp_err;
        lat   = i;
        break;
      end
      if (host_if.cmd_ready !== 1'b0) busy_bad++;
    end
    if (got) begin
      @(negedge clk_50MHz);
      post_valid = host_if.rsp_valid;
      post_ready = host_if.cmd_ready;
      $display("rsp rdata=%02h err=%0d latency=%0d", rdata, err, lat);
    end else begin
      $display("rsp none within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    vec_cnt++; if (host_if.cmd_ready !== 1'b1) begin miss_cnt++; $display("FAIL reset_cmd_ready got=%b exp=1", host_if.cmd_ready); end
    vec_cnt++; if (host_if.rsp_valid !== 1'b0) begin miss_cnt++; $display("FAIL reset_rsp_valid got=%b exp=0", host_if.rsp_valid); end
    vec_cnt++; if (host_if.rsp_rdata !== 8'h00) begin miss_cnt++; $display("FAIL reset_rsp_rdata got=%02h exp=00", host_if.rsp_rdata); end
    vec_cnt++; if (host_if.rsp_err !== 1'b0) begin miss_cnt++; $display("FAIL reset_rsp_err got=%b exp=0", host_if.rsp_err); end
    vec_cnt++; if (spi_start !== 1'b0) begin miss_cnt++; $display("FAIL reset_spi_start got=%b exp=0", spi_start); end
    vec_cnt++; if (spi_tx !== 8'h00) begin miss_cnt++; $display("FAIL reset_spi_tx got=%02h exp=00", spi_tx); end
    vec_cnt++; if (cs_n !== 1'b1) begin miss_cnt++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
    reset_n = 1'b1;
    repeat (2) @(posedge clk_50MHz);
  endtask

  task automatic test_write();
    bit ok, got; logic [7:0] rd; logic er, pv, pr; int lat, bb, f0, sn0;
    logic [7:0] exp [3] = '{8'h02, 8'h0F, 8'h80};
    slave_rx = '{8'h11, 8'h22, 8'h33, 8'h44};
    mosi_q.delete();
    f0 = frame_id; sn0 = start_no_cs;
    issue_cmd(3'd2, 8'h0F, 8'h80, 8'h00, ok);
    wait_rsp(2000, got, rd, er, lat, bb, pv, pr);
    vec_cnt++; if (!(ok && got)) begin miss_cnt++; $display("FAIL write_rsp accepted=%0d got=%0d exp=1/1", ok, got); end
    vec_cnt++; if (er !== 1'b0) begin miss_cnt++; $display("FAIL write_err got=%b exp=0", er); end
    vec_cnt++; if (rd !== 8'h00) begin miss_cnt++; $display("FAIL write_rdata got=%02h exp=00", rd); end
    vec_cnt++; if (mosi_q.size() != 3) begin miss_cnt++; $display("FAIL write_len got=%0d exp=3", mosi_q.size()); end
    for (int k = 0; k < 3 && k < mosi_q.size(); k++) begin
      vec_cnt++; if (mosi_q[k] !== exp[k]) begin miss_cnt++; $display("FAIL write_byte%0d got=%02h exp=%02h", k, mosi_q[k], exp[k]); end
    end
    vec_cnt++; if (frame_id - f0 != 1) begin miss_cnt++; $display("FAIL write_frames got=%0d exp=1", frame_id - f0); end
    vec_cnt++; if (start_no_cs != sn0) begin miss_cnt++; $display("FAIL write_start_outside_cs got=%0d exp=0", start_no_cs - sn0); end
    vec_cnt++; if (pv !== 1'b0 || pr !== 1'b1) begin miss_cnt++; $display("FAIL write_post_rsp valid=%b ready=%b exp=0/1", pv, pr); end
  endtask

  task automatic test_read();
    bit ok, got; logic [7:0] rd; logic er, pv, pr; int lat, bb, f0;
    logic [7:0] exp [3] = '{8'h03, 8'h0E, 8'h00};
    slave_rx = '{8'h11, 8'h22, 8'h40, 8'h44};
    mosi_q.delete();
    f0 = frame_id;
    issue_cmd(3'd1, 8'h0E, 8'h00, 8'h00, ok);
    wait_rsp(2000, got, rd, er, lat, bb, pv, pr);
    vec_cnt++; if (!(ok && got)) begin miss_cnt++; $display("FAIL read_rsp accepted=%0d got=%0d exp=1/1", ok, got); end
    vec_cnt++; if (rd !== 8'h40) begin miss_cnt++; $display("FAIL read_rdata got=%02h exp=40", rd); end
    vec_cnt++; if (er !== 1'b0) begin miss_cnt++; $display("FAIL read_err got=%b exp=0", er); end
    vec_cnt++; if (mosi_q.size() != 3) begin miss_cnt++; $display("FAIL read_len got=%0d exp=3", mosi_q.size()); end
    for (int k = 0; k < 3 && k < mosi_q.size(); k++) begin
      vec_cnt++; if (mosi_q[k] !== exp[k]) begin miss_cnt++; $display("FAIL read_byte%0d got=%02h exp=%02h", k, mosi_q[k], exp[k]); end
    end
    vec_cnt++; if (frame_id - f0 != 1) begin miss_cnt++; $display("FAIL read_frames got=%0d exp=1", frame_id - f0); end
    vec_cnt++; if (bb != 0) begin miss_cnt++; $display("FAIL read_ready_while_busy got=%0d exp=0", bb); end
  endtask

  task automatic test_back_to_back();
    bit ok, got; logic [7:0] rd; logic er, pv, pr; int lat, bb, f0;
    logic [7:0] exp [5] = '{8'h05, 8'h2B, 8'h03, 8'h01, 8'h81};
    slave_rx = '{8'h11, 8'h22, 8'h33, 8'h44};
    mosi_q.delete();
    f0 = frame_id;
    issue_cmd(3'd3, 8'h2B, 8'h01, 8'h03, ok);
    wait_rsp(2000, got, rd, er, lat, bb, pv, pr);
    vec_cnt++; if (!(ok && got) || er !== 1'b0 || rd !== 8'h00) begin miss_cnt++; $display("FAIL bitmod_rsp got=%0d err=%b rdata=%02h exp=1/0/00", got, er, rd); end
    issue_cmd(3'd5, 8'h01, 8'h00, 8'h00, ok);
    wait_rsp(2000, got, rd, er, lat, bb, pv, pr);
    vec_cnt++; if (!(ok && got) || er !== 1'b0 || rd !== 8'h00) begin miss_cnt++; $display("FAIL rts_rsp got=%0d err=%b rdata=%02h exp=1/0/00", got, er, rd); end
    vec_cnt++; if (mosi_q.size() != 5) begin miss_cnt++; $display("FAIL b2b_len got=%0d exp=5", mosi_q.size()); end
    for (int k = 0; k < 5 && k < mosi_q.size(); k++) begin
      vec_cnt++; if (mosi_q[k] !== exp[k]) begin miss_cnt++; $display("FAIL b2b_byte%0d got=%02h exp=%02h", k, mosi_q[k], exp[k]); end
    end
    vec_cnt++; if (frame_id - f0 != 2) begin miss_cnt++; $display("FAIL b2b_frames got=%0d exp=2", frame_id - f0); end
    vec_cnt++; if (last_gap < 80) begin miss_cnt++; $display("FAIL b2b_cs_gap got=%0d exp>=80", last_gap); end
  endtask

  task automatic test_illegal();
    bit ok, got; logic [7:0] rd; logic er, pv, pr; int lat, bb, s0, c0;
    s0 = start_cycles; c0 = cs_low_cycles;
    issue_cmd(3'd7, 8'h12, 8'h34, 8'h56, ok);
    wait_rsp(20, got, rd, er, lat, bb, pv, pr);
    vec_cnt++; if (!(ok && got)) begin miss_cnt++; $display("FAIL illegal_rsp accepted=%0d got=%0d exp=1/1", ok, got); end
    vec_cnt++; if (er !== 1'b1) begin miss_cnt++; $display("FAIL illegal_err got=%b exp=1", er); end
    vec_cnt++; if (rd !== 8'h00) begin miss_cnt++; $display("FAIL illegal_rdata got=%02h exp=00", rd); end
    vec_cnt++; if (lat > 2) begin miss_cnt++; $display("FAIL illegal_latency got=%0d exp<=2", lat); end
    vec_cnt++; if (start_cycles != s0) begin miss_cnt++; $display("FAIL illegal_spi_start got=%0d exp=0", start_cycles - s0); end
    vec_cnt++; if (cs_low_cycles != c0) begin miss_cnt++; $display("FAIL illegal_cs_low got=%0d exp=0", cs_low_cycles - c0); end
  endtask

  task automatic test_reset_midframe();
    bit ok, got; logic [7:0] rd; logic er, pv, pr; int lat, bb, n, r0;
    logic pre_start;
    slave_rx = '{8'h11, 8'h22, 8'h40, 8'h44};
    mosi_q.delete();
    issue_cmd(3'd1, 8'h0E, 8'h00, 8'h00, ok);
    n = 0;
    while (mosi_q.size() < 2 && n < 2000) begin
      @(negedge clk_50MHz);
      n++;
    end
    pre_start = spi_start;
    vec_cnt++; if (mosi_q.size() < 2 || pre_start !== 1'b1) begin miss_cnt++; $display("FAIL midframe_second_byte bytes=%0d start=%b exp=2/1", mosi_q.size(), pre_start); end
    reset_n = 1'b0;
    #1;
    vec_cnt++; if (cs_n !== 1'b1) begin miss_cnt++; $display("FAIL midframe_cs_n got=%b exp=1", cs_n); end
    vec_cnt++; if (spi_start !== 1'b0) begin miss_cnt++; $display("FAIL midframe_spi_start got=%b exp=0", spi_start); end
    $display("reset asserted during byte 2 of READ");
    repeat (3) @(posedge clk_50MHz);
    #1 reset_n = 1'b1;
    r0 = rsp_cycles;
    repeat (60) @(negedge clk_50MHz);
    vec_cnt++; if (rsp_cycles != r0) begin miss_cnt++; $display("FAIL midframe_no_rsp got=%0d exp=0", rsp_cycles - r0); end
    slave_rx = '{8'h11, 8'h0C, 8'h33, 8'h44};
    mosi_q.delete();
    issue_cmd(3'd4, 8'h00, 8'h00, 8'h00, ok);
    wait_rsp(2000, got, rd, er, lat, bb, pv, pr);
    vec_cnt++; if (!(ok && got) || rd !== 8'h0C || er !== 1'b0) begin miss_cnt++; $display("FAIL status_rsp got=%0d rdata=%02h err=%b exp=1/0C/0", got, rd, er); end
    vec_cnt++; if (mosi_q.size() != 2 || mosi_q[0] !== 8'hA0 || mosi_q[1] !== 8'h00) begin miss_cnt++; $display("FAIL status_frame len=%0d exp=2 bytes A0,00", mosi_q.size()); end
  endtask

  task automatic test_timeout();
    bit ok, got; logic [7:0] rd; logic er, pv, pr; int lat, bb;
    model_stuck = 1'b1;
    issue_cmd(3'd0, 8'h00, 8'h00, 8'h00, ok);
    wait_rsp(9000, got, rd, er, lat, bb, pv, pr);
`ifdef SEQ_TIMEOUT_EN
    vec_cnt++; if (!got || er !== 1'b1 || rd !== 8'h00) begin miss_cnt++; $display("FAIL timeout_rsp got=%0d err=%b rdata=%02h exp=1/1/00", got, er, rd); end
    vec_cnt++; if (cs_n !== 1'b1) begin miss_cnt++; $display("FAIL timeout_cs_n got=%b exp=1", cs_n); end
`else
    vec_cnt++; if (got) begin miss_cnt++; $display("FAIL stuck_rsp got=1 exp=0"); end
    vec_cnt++; if (cs_n !== 1'b0 || spi_start !== 1'b1) begin miss_cnt++; $display("FAIL stuck_bus cs_n=%b start=%b exp=0/1", cs_n, spi_start); end
`endif
    reset_n = 1'b0;
    repeat (3) @(posedge clk_50MHz);
    #1 reset_n = 1'b1;
    model_stuck = 1'b0;
    repeat (5) @(posedge clk_50MHz);
  endtask

  initial begin
    host_if.cmd_valid = 1'b0;
    host_if.cmd_op    = 3'd0;
    host_if.cmd_addr  = 8'h00;
    host_if.cmd_wdata = 8'h00;
    host_if.cmd_mask  = 8'h00;
    slave_rx = '{8'h11, 8'h22, 8'h33, 8'h44};
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_illegal();
    test_reset_midframe();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
